// File: rtl/car_motion_ctrl.sv
// car_motion_ctrl: elevator car motion and door sequencer; times floor travel and door dwell,
// reports car state, location and a registered arrival pulse.
module car_motion_ctrl #(
  parameter int NUM_FLOORS    = 5,
  parameter int TRAVEL_CYCLES = 50,
  parameter int DOOR_CYCLES   = 100
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  enable,
  input  logic [2:0]            dest,
  input  logic [NUM_FLOORS-1:0] pend,
  input  logic                  door_hold,
  output logic [1:0]            state,
  output logic [2:0]            location,
  output logic                  door_open,
  output logic                  arrive
);
  typedef enum logic [1:0] {IDLE, DOOR, UP, DOWN} st_t;
  localparam int MAXC = (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES : DOOR_CYCLES;
  localparam int CW = $clog2(MAXC);
  localparam logic [2:0] NF = 3'(NUM_FLOORS);
  localparam logic [CW-1:0] T_LAST = CW'(TRAVEL_CYCLES - 1);
  localparam logic [CW-1:0] D_LAST = CW'(DOOR_CYCLES - 1);
  st_t st;
  logic [CW-1:0] tcnt, dcnt;
  logic [2:0] next_loc, tgt, tgt_n;
  logic valid, pend_here, at_bound;
  always_comb begin
    valid     = dest != 3'd0 && dest <= NF;
    next_loc  = (st == UP) ? location + 3'd1 : location - 3'd1;
    tgt       = valid ? dest : location;
    tgt_n     = valid ? dest : next_loc;
    pend_here = pend[location - 3'd1];
    at_bound  = (st == UP && location == NF) || (st == DOWN && location == 3'd1);
  end
  assign state     = st;
  assign door_open = st == DOOR;
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      st       <= IDLE;
      location <= 3'd1;
      arrive   <= 1'b0;
      tcnt     <= '0;
      dcnt     <= '0;
    end else if (!enable) begin
      arrive <= 1'b0;
    end else begin
      arrive <= 1'b0;
      case (st)
        IDLE: begin
          if (pend_here) begin
            st   <= DOOR;
            dcnt <= '0;
          end else if (tgt != location) begin
            st   <= (tgt > location) ? UP : DOWN;
            tcnt <= '0;
          end
        end
        UP, DOWN: begin
          if (at_bound) st <= IDLE;
          else if (tcnt == T_LAST) begin
            // floor boundary: the only point where dest is re-examined
            tcnt     <= '0;
            location <= next_loc;
            arrive   <= 1'b1;
            if (tgt_n == next_loc) begin
              st   <= DOOR;
              dcnt <= '0;
            end else if ((st == UP) ? tgt_n < next_loc : tgt_n > next_loc) st <= IDLE;
          end else tcnt <= tcnt + 1'b1;
        end
        DOOR: begin
          if (door_hold) dcnt <= '0;
          else if (dcnt == D_LAST) st <= IDLE;
          else dcnt <= dcnt + 1'b1;
        end
        default: st <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_car_motion_ctrl.sv
// tb_car_motion_ctrl: scripted scoreboard bench for car_motion_ctrl with TRAVEL=4, DOOR=6.
module tb_car_motion_ctrl;
  localparam int T = 4, D = 6;
  logic clk = 1'b0, resetn = 1'b0, enable = 1'b0, door_hold = 1'b0;
  logic [2:0] dest = 3'd1;
  logic [4:0] pend = 5'd0;
  logic [1:0] state;
  logic [2:0] location;
  logic door_open, arrive;
  int n_chk = 0, n_pass = 0, step = 0;
  typedef struct {logic [1:0] st; logic [2:0] loc; logic arr;} exp_t;
  exp_t sb[$];

  car_motion_ctrl #(.NUM_FLOORS(5), .TRAVEL_CYCLES(T), .DOOR_CYCLES(D)) dut (
    .clk(clk), .resetn(resetn), .enable(enable), .dest(dest), .pend(pend),
    .door_hold(door_hold), .state(state), .location(location),
    .door_open(door_open), .arrive(arrive));

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s step %0d: got %0d expected %0d", tag, step, got, exp);
  endtask

  task automatic cyc(input logic [1:0] es, input logic [2:0] el, input logic ea);
    exp_t e;
    sb.push_back('{es, el, ea});
    @(posedge clk);
    #1;
    step++;
    e = sb.pop_front();
    check("state", int'(state), int'(e.st));
    check("location", int'(location), int'(e.loc));
    check("arrive", int'(arrive), int'(e.arr));
    check("door_open", int'(door_open), int'(e.st == 2'd1));
  endtask

  task automatic leg(input logic [1:0] es, input logic [2:0] from, input logic [2:0] to,
                     input logic [1:0] after);
    repeat (T - 1) cyc(es, from, 1'b0);
    cyc(after, to, 1'b1);
  endtask

  task automatic dwell(input logic [2:0] loc);
    repeat (D - 1) cyc(2'd1, loc, 1'b0);
    cyc(2'd0, loc, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    #12;
    check("rst_state", int'(state), 0);
    check("rst_location", int'(location), 1);
    check("rst_door_open", int'(door_open), 0);
    check("rst_arrive", int'(arrive), 0);
    resetn = 1'b1;
    enable = 1'b1;
    // travel 1 -> 3, door dwell
    dest = 3'd3;
    cyc(2'd2, 3'd1, 1'b0);
    leg(2'd2, 3'd1, 3'd2, 2'd2);
    leg(2'd2, 3'd2, 3'd3, 2'd1);
    dwell(3'd3);
    // down to 2
    dest = 3'd2;
    cyc(2'd3, 3'd3, 1'b0);
    leg(2'd3, 3'd3, 3'd2, 2'd1);
    dwell(3'd2);
    // call at current floor, then door_hold for 10 cycles
    pend = 5'b00010;
    cyc(2'd1, 3'd2, 1'b0);
    pend = 5'd0;
    door_hold = 1'b1;
    repeat (10) cyc(2'd1, 3'd2, 1'b0);
    door_hold = 1'b0;
    dwell(3'd2);
    // enable low for 7 cycles mid-floor delays the arrival by 7
    dest = 3'd4;
    cyc(2'd2, 3'd2, 1'b0);
    repeat (2) cyc(2'd2, 3'd2, 1'b0);
    enable = 1'b0;
    dest = 3'd1;
    pend = 5'b11111;
    repeat (7) cyc(2'd2, 3'd2, 1'b0);
    enable = 1'b1;
    dest = 3'd4;
    pend = 5'd0;
    cyc(2'd2, 3'd2, 1'b0);
    cyc(2'd2, 3'd3, 1'b1);
    leg(2'd2, 3'd3, 3'd4, 2'd1);
    dwell(3'd4);
    // down to 1
    dest = 3'd1;
    cyc(2'd3, 3'd4, 1'b0);
    leg(2'd3, 3'd4, 3'd3, 2'd3);
    leg(2'd3, 3'd3, 3'd2, 2'd3);
    leg(2'd3, 3'd2, 3'd1, 2'd1);
    dwell(3'd1);
    // heading for 5, dest lowered to 2 mid-floor -> stop at 2
    dest = 3'd5;
    cyc(2'd2, 3'd1, 1'b0);
    repeat (2) cyc(2'd2, 3'd1, 1'b0);
    dest = 3'd2;
    cyc(2'd2, 3'd1, 1'b0);
    cyc(2'd1, 3'd2, 1'b1);
    dwell(3'd2);
    // up to top floor
    dest = 3'd5;
    cyc(2'd2, 3'd2, 1'b0);
    leg(2'd2, 3'd2, 3'd3, 2'd2);
    leg(2'd2, 3'd3, 3'd4, 2'd2);
    leg(2'd2, 3'd4, 3'd5, 2'd1);
    dwell(3'd5);
    // invalid dest values leave the car idle at 5
    dest = 3'd7;
    repeat (4) cyc(2'd0, 3'd5, 1'b0);
    dest = 3'd6;
    cyc(2'd0, 3'd5, 1'b0);
    dest = 3'd0;
    cyc(2'd0, 3'd5, 1'b0);
    // going down, dest moved behind mid-floor -> idle at next floor
    dest = 3'd1;
    cyc(2'd3, 3'd5, 1'b0);
    cyc(2'd3, 3'd5, 1'b0);
    dest = 3'd5;
    repeat (2) cyc(2'd3, 3'd5, 1'b0);
    cyc(2'd0, 3'd4, 1'b1);
    dest = 3'd4;
    cyc(2'd0, 3'd4, 1'b0);
    // asynchronous reset mid-travel
    dest = 3'd5;
    cyc(2'd2, 3'd4, 1'b0);
    cyc(2'd2, 3'd4, 1'b0);
    #2;
    resetn = 1'b0;
    #1;
    check("async_rst_state", int'(state), 0);
    check("async_rst_location", int'(location), 1);
    check("async_rst_door_open", int'(door_open), 0);
    check("async_rst_arrive", int'(arrive), 0);
    #20;
    check("rst_held_location", int'(location), 1);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
